// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the EX-stage iterative divider.
//   div_state_e      : 2-bit sequencer state (FREE / BY_ZERO / ON / END)
//   DIV_RESULT_*     : values carried on ready_o
//   DIV_START/STOP   : values carried on start_i
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX <-> divider handshake bundle.
//   start_i, signed_div_i, opdata1_i, opdata2_i, annul_i : EX -> divider
//   result_o {remainder, quotient}, ready_o              : divider -> EX
//   stallreq                                             : divider -> stall controller
// Modports: master (EX side), slave (divider side).
interface div_ctrl_if #(
  parameter int DW = 32
);
  logic              start_i;
  logic              signed_div_i;
  logic [DW-1:0]     opdata1_i;
  logic [DW-1:0]     opdata2_i;
  logic              annul_i;
  logic [2*DW-1:0]   result_o;
  logic              ready_o;
  logic              stallreq;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq
  );
endinterface

// File: rtl/div_ctrl_step.sv
// div_step: one combinational restoring-division iteration.
//   work_i    : working register {partial remainder (DW+1), dividend/quotient (DW)}
//   divisor_i : |divisor|
//   work_o    : working register after the step (quotient bit already in bit 0)
//   qbit_o    : quotient bit produced by this step
module div_step #(
  parameter int DW = 32
) (
  input  logic [2*DW:0] work_i,
  input  logic [DW-1:0] divisor_i,
  output logic [2*DW:0] work_o,
  output logic          qbit_o
);

  logic [2*DW:0] shifted;
  logic [DW:0]   trial;

  always_comb begin
    shifted = work_i << 1;
    trial   = shifted[2*DW:DW] - {1'b0, divisor_i};
    // The partial remainder is always below 2*divisor, so a borrow shows
    // up as the MSB of the (DW+1)-bit trial difference.
    qbit_o  = ~trial[DW];
    work_o  = shifted;
    if (qbit_o) begin
      work_o[2*DW:DW] = trial;
    end
    work_o[0] = qbit_o;
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequences a radix-2 restoring divider for DIV/DIVU in EX.
//   clk, rst (synchronous, active-low)
//   bus.slave : start_i/signed_div_i/opdata1_i/opdata2_i/annul_i in,
//               result_o {rem, quo}, ready_o (1-cycle pulse), stallreq out.
// Operands are converted to magnitudes on entry to ON; DW iterations run on
// the magnitudes and the signs are re-applied when the result is written.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 6     // needs 2**CNT_W > DW
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*DW:0]    work_q, work_d;
  logic [DW-1:0]    divisor_q, divisor_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [2*DW-1:0]  result_q, result_d;
  logic             ready_q, ready_d;

  logic [DW-1:0]    op1_abs, op2_abs;
  logic [2*DW:0]    step_work;
  logic             step_qbit;
  logic [DW-1:0]    raw_quot, raw_rem;
  logic             go;

  div_step #(.DW(DW)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_work),
    .qbit_o    (step_qbit)
  );

  assign go = (bus.start_i == DIV_START) && !bus.annul_i;

  // Magnitudes; the most negative value maps onto itself, which is the
  // correct unsigned magnitude 2**(DW-1).
  assign op1_abs = (bus.signed_div_i && bus.opdata1_i[DW-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i && bus.opdata2_i[DW-1]) ? -bus.opdata2_i : bus.opdata2_i;

  assign raw_quot = {step_work[DW-1:1], step_qbit};
  assign raw_rem  = step_work[2*DW-1:DW];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = DIV_RESULT_NOT_READY;

    case (state_q)
      DIV_FREE: begin
        if (go) begin
          if (bus.opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d    = DIV_ON;
            work_d     = {{(DW+1){1'b0}}, op1_abs};
            divisor_d  = op2_abs;
            neg_quot_d = bus.signed_div_i & (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
            neg_rem_d  = bus.signed_div_i & bus.opdata1_i[DW-1];
            cnt_d      = '0;
          end
        end
      end

      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
      end

      DIV_ON: begin
        if (bus.annul_i) begin
          state_d = DIV_FREE;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DW-1)) begin
            state_d  = DIV_END;
            result_d = {neg_rem_q  ? -raw_rem  : raw_rem,
                        neg_quot_q ? -raw_quot : raw_quot};
            ready_d  = DIV_RESULT_READY;
          end
        end
      end

      DIV_END: begin
        state_d = DIV_FREE;
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  // Released in END so EX advances on the same edge that captures result_o.
  assign bus.stallreq = go && (state_q != DIV_END);

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: table-driven and randomized checks of div_ctrl against an
// arithmetic reference (64-bit integer division, truncating toward zero).
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  div_ctrl_if #(.DW(32)) bus ();

  div_ctrl #(.DW(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at a drive point (1 time unit after posedge) with the DUT in FREE.
  // Cycle 0 is the cycle in which start_i is first seen. Operands are
  // scrambled while busy to show that only the entry values matter.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output logic [63:0] res, output int lat, output int stalls,
                       output logic stall_at_ready);
    bus.start_i      = DIV_START;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    lat = -1; stalls = 0; res = '0; stall_at_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.stallreq) stalls++;
      if (bus.ready_o) begin
        lat = c;
        res = bus.result_o;
        stall_at_ready = bus.stallreq;
        break;
      end
      tick();
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = 1'($urandom);
    end
    tick();
    bus.start_i = DIV_STOP;
    $display("op %h / %h signed=%0d -> result %h latency %0d", a, b, sgn, res, lat);
  endtask

  task automatic run_checked(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic sgn, input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int          lat, stalls;
    logic        sar;
    do_op(a, b, sgn, res, lat, stalls, sar);
    check({name, ".result"}, res, exp);
    check({name, ".latency"}, 64'(lat), 64'(exp_lat));
    check({name, ".stall_cycles"}, 64'(stalls), 64'(exp_lat));
    check({name, ".stall_at_ready"}, 64'(sar), 64'd0);
    #1;
    check({name, ".ready_pulse"}, 64'(bus.ready_o), 64'd0);
    check({name, ".free_after"}, 64'(dut.state_q), 64'(DIV_FREE));
  endtask

  initial begin
    logic [63:0] res_a, res_b, prev_res;
    int          lat_a, lat_b, st_a, st_b, readies;
    logic        sar_a, sar_b, rsgn;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                 33};
    vecs[1] = '{32'hFFFFFFF9,   32'h2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},   33};
    vecs[2] = '{32'h7,          32'hFFFFFFFE,   1'b1, {32'h00000001, 32'hFFFFFFFD},   33};
    vecs[3] = '{32'h1234,       32'h0,          1'b0, 64'd0,                           2};
    vecs[4] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h0, 32'h80000000},          33};
    vecs[5] = '{32'hFFFFFFFF,   32'h1,          1'b0, {32'h0, 32'hFFFFFFFF},          33};
    vecs[6] = '{32'd9,          32'd3,          1'b0, {32'd0, 32'd3},                 33};
    vecs[7] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, {32'd0, 32'd1},                 33};
    vecs[8] = '{32'hFFFFFFF8,   32'h0,          1'b1, 64'd0,                           2};

    bus.start_i      = DIV_STOP;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.annul_i      = 1'b0;

    // Reset state.
    rst = 1'b0;
    repeat (3) tick();
    #1;
    check("reset.ready", 64'(bus.ready_o), 64'd0);
    check("reset.result", bus.result_o, 64'd0);
    check("reset.stallreq", 64'(bus.stallreq), 64'd0);
    check("reset.state", 64'(dut.state_q), 64'(DIV_FREE));
    rst = 1'b1;
    tick();

    foreach (vecs[i])
      run_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].lat);

    // Flush during ON at cycle 10.
    tick();
    prev_res = bus.result_o;
    bus.start_i = DIV_START; bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.annul_i = 1'b0;
    repeat (10) tick();
    bus.annul_i = 1'b1;
    #1;
    check("annul.stallreq", 64'(bus.stallreq), 64'd0);
    tick();
    #1;
    check("annul.state", 64'(dut.state_q), 64'(DIV_FREE));
    bus.start_i = DIV_STOP; bus.annul_i = 1'b0;
    readies = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.ready_o) readies++;
    end
    check("annul.no_ready", 64'(readies), 64'd0);
    check("annul.result_held", bus.result_o, prev_res);
    run_checked("annul.next", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

    // Reset at cycle 20 of an operation.
    tick();
    bus.start_i = DIV_START; bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'hDEADBEEF; bus.opdata2_i = 32'd3;
    repeat (20) tick();
    rst = 1'b0;
    tick();
    bus.start_i = DIV_STOP;
    #1;
    check("midrst.ready", 64'(bus.ready_o), 64'd0);
    check("midrst.result", bus.result_o, 64'd0);
    check("midrst.stallreq", 64'(bus.stallreq), 64'd0);
    check("midrst.state", 64'(dut.state_q), 64'(DIV_FREE));
    rst = 1'b1;
    readies = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.ready_o) readies++;
    end
    check("midrst.no_ready", 64'(readies), 64'd0);

    // Back-to-back: second start the cycle after END.
    tick();
    do_op(32'd1000, 32'd7, 1'b0, res_a, lat_a, st_a, sar_a);
    do_op(32'hFFFFFF9C, 32'd9, 1'b1, res_b, lat_b, st_b, sar_b);
    check("b2b.first.result", res_a, {32'd6, 32'd142});
    check("b2b.first.latency", 64'(lat_a), 64'd33);
    check("b2b.second.result", res_b, {32'hFFFFFFFF, 32'hFFFFFFF5});
    check("b2b.second.latency", 64'(lat_b), 64'd33);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(0, 5));
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      rsgn = 1'($urandom);
      run_checked($sformatf("rand%0d", i), ra, rb, rsgn, ref_div(ra, rb, rsgn),
                  (rb == 32'd0) ? 2 : 33);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
